// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage for the 16-bit / 13-bit-PC pipeline.
// The block owns the program counter. It issues one instruction-memory read
// at a time and holds each fetched word in an output register until decode
// accepts it. Fetch stops on a halt opcode (inst[15:12] == 0), and a redirect
// from branch/jump resolution restarts fetch at a new PC.
//
// Ports:
//   clk, rst_n                : clock and asynchronous active-low reset
//   imem_req, imem_addr       : read request (one cycle) and its address (= pc)
//   imem_rvalid, imem_rdata   : read response; rvalid outside WAIT is ignored
//   if_valid, if_ready        : output handshake towards decode
//   if_pc, if_pc_plus1,
//   if_inst                   : fetched instruction, its address and address+1
//   redirect_valid,
//   redirect_pc               : load a new pc and squash in-flight work
//   halted                    : fetch stopped on a halt opcode
module fetch_unit #(
    parameter int              PC_W     = 13,
    parameter int              INST_W   = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [PC_W-1:0]   if_pc,
    output logic [PC_W-1:0]   if_pc_plus1,
    output logic [INST_W-1:0] if_inst,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              halted
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_OUT,
        S_HALT
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [PC_W-1:0]   pc;
    logic              squash;

    logic              is_halt_op;
    logic              capture;
    logic              transfer;
    logic              enter_halt;
    logic              leave_out;

    assign is_halt_op = (if_inst[INST_W-1 -: 4] == 4'b0000);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (!redirect_valid) state_d = S_WAIT;
            end
            S_WAIT: begin
                // A redirect arriving with the response also discards it.
                if (imem_rvalid) begin
                    state_d = (squash || redirect_valid) ? S_FETCH : S_OUT;
                end
            end
            S_OUT: begin
                if (redirect_valid) begin
                    state_d = S_FETCH;
                end else if (if_ready) begin
                    state_d = is_halt_op ? S_HALT : S_FETCH;
                end
            end
            S_HALT: begin
                if (redirect_valid) state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Output / control strobes
    always_comb begin
        imem_req   = (state_q == S_FETCH) && !redirect_valid;
        imem_addr  = pc;
        capture    = (state_q == S_WAIT) && imem_rvalid && !squash && !redirect_valid;
        transfer   = (state_q == S_OUT) && if_ready && !redirect_valid;
        enter_halt = transfer && is_halt_op;
        leave_out  = (state_q == S_OUT) && (if_ready || redirect_valid);
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            squash      <= 1'b0;
            if_valid    <= 1'b0;
            if_pc       <= '0;
            if_pc_plus1 <= '0;
            if_inst     <= '0;
            halted      <= 1'b0;
        end else begin
            // A redirect wins over the pc increment in every state.
            if (redirect_valid) begin
                pc <= redirect_pc;
            end else if (transfer && !is_halt_op) begin
                pc <= pc + PC_W'(1);
            end

            if (state_q == S_WAIT) begin
                if (imem_rvalid) begin
                    squash <= 1'b0;
                end else if (redirect_valid) begin
                    squash <= 1'b1;
                end
            end

            if (capture) begin
                if_valid    <= 1'b1;
                if_inst     <= imem_rdata;
                if_pc       <= pc;
                if_pc_plus1 <= pc + PC_W'(1);
            end else if (leave_out) begin
                if_valid <= 1'b0;
            end

            if (enter_halt) begin
                halted <= 1'b1;
            end else if ((state_q == S_HALT) && redirect_valid) begin
                halted <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit. A latency-configurable
// instruction memory answers requests, and a flag-based reference model
// predicts every output cycle by cycle. Directed phases are followed by a
// randomized phase.
module tb_fetch_unit;

    localparam int PC_W   = 13;
    localparam int INST_W = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              imem_req;
    logic [PC_W-1:0]   imem_addr;
    logic              imem_rvalid;
    logic [INST_W-1:0] imem_rdata;
    logic              if_valid;
    logic              if_ready;
    logic [PC_W-1:0]   if_pc;
    logic [PC_W-1:0]   if_pc_plus1;
    logic [INST_W-1:0] if_inst;
    logic              redirect_valid;
    logic [PC_W-1:0]   redirect_pc;
    logic              halted;

    // Second instance exercising the wrap-around reset PC.
    logic              w_req;
    logic [PC_W-1:0]   w_addr;
    logic              w_rvalid;
    logic [INST_W-1:0] w_rdata;
    logic              w_valid;
    logic              w_ready;
    logic [PC_W-1:0]   w_pc;
    logic [PC_W-1:0]   w_pcp1;
    logic [INST_W-1:0] w_inst;
    logic              w_halted;

    always #5 clk = ~clk;

    fetch_unit #(.PC_W(PC_W), .INST_W(INST_W), .RESET_PC(13'h0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_ready(if_ready),
        .if_pc(if_pc), .if_pc_plus1(if_pc_plus1), .if_inst(if_inst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halted(halted)
    );

    fetch_unit #(.PC_W(PC_W), .INST_W(INST_W), .RESET_PC(13'h1FFF)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
        .if_valid(w_valid), .if_ready(w_ready),
        .if_pc(w_pc), .if_pc_plus1(w_pcp1), .if_inst(w_inst),
        .redirect_valid(1'b0), .redirect_pc(13'h0000),
        .halted(w_halted)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned cyc   = 0;
    int unsigned lat   = 1;

    // Memory: contents and in-flight responses.
    logic [INST_W-1:0] mem [0:(1<<PC_W)-1];
    typedef struct {
        int unsigned     due;
        logic [PC_W-1:0] addr;
    } rsp_t;
    rsp_t rq[$];

    // Reference model state.
    logic [PC_W-1:0]   m_pc;
    logic              m_busy;   // a read is outstanding
    logic              m_stale;  // the outstanding read was redirected away
    logic              m_have;   // an instruction is offered to decode
    logic              m_halt;
    logic [PC_W-1:0]   m_ipc;
    logic [PC_W-1:0]   m_ipc1;
    logic [INST_W-1:0] m_inst;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 13'h0000; m_busy = 0; m_stale = 0; m_have = 0; m_halt = 0;
        m_ipc = '0; m_ipc1 = '0; m_inst = '0;
    endtask

    task automatic do_reset(input int unsigned ncyc);
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        imem_rvalid = 1'b0;
        #1;
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_if_inst", 32'(if_inst), 32'd0);
        chk("rst_if_pc", 32'(if_pc), 32'd0);
        chk("rst_if_pc_plus1", 32'(if_pc_plus1), 32'd0);
        model_reset();
        repeat (ncyc) begin
            @(posedge clk); #1; cyc++;
        end
        rst_n = 1'b1;
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance.
    task automatic tick(input logic redir, input logic [PC_W-1:0] rpc, input logic rdy);
        logic e_req;
        redirect_valid = redir;
        redirect_pc    = rpc;
        if_ready       = rdy;
        imem_rvalid    = 1'b0;
        imem_rdata     = 16'($urandom);
        while (rq.size() > 0 && rq[0].due < cyc) void'(rq.pop_front());
        if (rq.size() > 0 && rq[0].due == cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem[rq[0].addr];
            void'(rq.pop_front());
        end
        #1;
        e_req = !m_busy && !m_have && !m_halt && !redir;
        chk("imem_req", 32'(imem_req), 32'(e_req));
        if (e_req) chk("imem_addr", 32'(imem_addr), 32'(m_pc));
        chk("if_valid", 32'(if_valid), 32'(m_have));
        chk("halted", 32'(halted), 32'(m_halt));
        if (m_have) begin
            chk("if_pc", 32'(if_pc), 32'(m_ipc));
            chk("if_pc_plus1", 32'(if_pc_plus1), 32'(m_ipc1));
            chk("if_inst", 32'(if_inst), 32'(m_inst));
        end
        if (imem_req) rq.push_back('{cyc + lat, imem_addr});

        if (m_busy) begin
            if (redir) begin
                m_pc = rpc;
                if (imem_rvalid) begin m_busy = 0; m_stale = 0; end
                else m_stale = 1;
            end else if (imem_rvalid) begin
                m_busy = 0;
                if (m_stale) m_stale = 0;
                else begin
                    m_have = 1; m_inst = mem[m_pc]; m_ipc = m_pc; m_ipc1 = m_pc + 13'd1;
                end
            end
        end else if (m_have) begin
            if (redir) begin
                m_have = 0; m_pc = rpc;
            end else if (rdy) begin
                m_have = 0;
                if (m_inst[15:12] == 4'h0) m_halt = 1;
                else m_pc = m_pc + 13'd1;
            end
        end else if (m_halt) begin
            if (redir) begin m_halt = 0; m_pc = rpc; end
        end else begin
            if (redir) m_pc = rpc;
            else m_busy = 1;
        end

        @(posedge clk); #1; cyc++;
    endtask

    // Run until the model is idle in fetch (or halted), then redirect there.
    task automatic goto_pc(input logic [PC_W-1:0] target);
        int unsigned n = 0;
        while ((m_busy || m_have) && n < 50) begin
            tick(1'b0, '0, 1'b1);
            n++;
        end
        chk("goto_timeout", 32'(m_busy || m_have), 32'd0);
        tick(1'b1, target, 1'b1);
    endtask

    initial begin
        int unsigned nreq;
        int unsigned bad;
        rst_n = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b1;
        imem_rvalid = 1'b0; imem_rdata = '0;
        w_rvalid = 1'b0; w_rdata = '0; w_ready = 1'b1;
        for (int a = 0; a < (1 << PC_W); a++) mem[a] = 16'hC000 + 16'(a);
        mem[3] = 16'h0000;
        @(posedge clk); #1;
        do_reset(2);

        // Wrap: RESET_PC = 1FFF.
        #1;
        chk("wrap_req", 32'(w_req), 32'd1);
        chk("wrap_addr", 32'(w_addr), 32'h1FFF);
        @(posedge clk); #1;
        w_rvalid = 1'b1; w_rdata = 16'hDFFF;
        @(posedge clk); #1;
        w_rvalid = 1'b0;
        #1;
        chk("wrap_valid", 32'(w_valid), 32'd1);
        chk("wrap_pc", 32'(w_pc), 32'h1FFF);
        chk("wrap_pc_plus1", 32'(w_pcp1), 32'h0000);
        chk("wrap_inst", 32'(w_inst), 32'hDFFF);
        @(posedge clk); #1;
        #1;
        chk("wrap_next_req", 32'(w_req), 32'd1);
        chk("wrap_next_addr", 32'(w_addr), 32'h0000);
        @(posedge clk); #1;

        do_reset(2);

        // Streaming at L=1, then halt at pc=3.
        lat = 1;
        repeat (12) tick(1'b0, '0, 1'b1);
        chk("halted_after_op", 32'(halted), 32'd1);
        nreq = 0;
        repeat (20) begin
            if (imem_req) nreq++;
            tick(1'b0, '0, 1'b1);
        end
        chk("halt_no_req", nreq, 32'd0);
        tick(1'b1, 13'h0010, 1'b1);
        repeat (6) tick(1'b0, '0, 1'b1);

        // Backpressure at pc=4.
        goto_pc(13'h0004);
        repeat (2) tick(1'b0, '0, 1'b1);
        repeat (5) tick(1'b0, '0, 1'b0);
        repeat (4) tick(1'b0, '0, 1'b1);

        // Squash: redirect one cycle after the request to addr 7, L=4.
        lat = 4;
        goto_pc(13'h0007);
        tick(1'b0, '0, 1'b1);
        tick(1'b1, 13'h0100, 1'b1);
        bad = 0;
        repeat (14) begin
            if (if_valid && if_pc == 13'h0007) bad++;
            tick(1'b0, '0, 1'b1);
        end
        chk("squash_drop", bad, 32'd0);

        // Redirect in OUT with if_ready=1, then a redirect in FETCH.
        lat = 1;
        goto_pc(13'h0020);
        repeat (2) tick(1'b0, '0, 1'b1);
        tick(1'b1, 13'h0030, 1'b1);
        tick(1'b1, 13'h0040, 1'b1);
        repeat (6) tick(1'b0, '0, 1'b1);

        // Reset while a read is outstanding; its response lands in FETCH.
        lat = 3;
        goto_pc(13'h0050);
        tick(1'b0, '0, 1'b1);
        do_reset(2);
        repeat (10) tick(1'b0, '0, 1'b1);

        // Randomized phase with scattered halt opcodes.
        for (int i = 0; i < 600; i++) mem[$urandom_range(0, (1 << PC_W) - 1)] = {4'h0, 12'($urandom)};
        for (int i = 0; i < 1500; i++) begin
            logic [PC_W-1:0] rpc;
            lat = $urandom_range(1, 4);
            rpc = ($urandom_range(0, 3) == 0) ? 13'h1FFE + 13'($urandom_range(0, 1)) : 13'($urandom);
            tick(($urandom_range(0, 99) < 8), rpc, ($urandom_range(0, 99) < 70));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
